// File: rtl/fifo_param_flag.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
// A read and a write in the same cycle on a full FIFO are both accepted: the
// read frees the oldest slot while the write fills it, so full stays high.
module fifo_param_flag #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         d_in,
   input  logic                     wr,
   input  logic                     rd,
   output logic [WIDTH-1:0]         d_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF    = CW'(AF_THRESH);
   localparam logic [CW-1:0] CNT_AE    = CW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] d_out_q;
   logic             overflow_q;
   logic             underflow_q;

   logic             wr_ok;
   logic             rd_ok;

   // Flags decode the registered count only, so no input reaches an output
   // without passing through a register.
   always_comb begin
      full         = (count_q == CNT_DEPTH);
      empty        = (count_q == '0);
      almost_full  = (count_q >= CNT_AF);
      almost_empty = (count_q <= CNT_AE);
   end

   // Acceptance: a write may proceed when full only if a read frees a slot.
   always_comb begin
      wr_ok = wr && (!full || rd);
      rd_ok = rd && !empty;
   end

   // Storage array; not reset, and a reset cycle blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wr_ptr] <= d_in;
      end
   end

   // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Occupancy tracks accepted writes minus accepted reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Registered read data; holds when no read is accepted (no write-through).
   always_ff @(posedge clk) begin
      if (rst) begin
         d_out_q <= '0;
      end else if (rd_ok) begin
         d_out_q <= mem[rd_ptr];
      end
   end

   // Error pulses last exactly one cycle after a rejected request.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= wr && !wr_ok;
         underflow_q <= rd && !rd_ok;
      end
   end

   assign d_out     = d_out_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_param_flag.sv
// Bench for fifo_param_flag: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_fifo_param_flag;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] d_in;
   logic             wr;
   logic             rd;
   logic [WIDTH-1:0] d_out;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [4:0]       count;
   logic             overflow;
   logic             underflow;

   fifo_param_flag #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk), .rst(rst), .d_in(d_in), .wr(wr), .rd(rd),
      .d_out(d_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // reference model state
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_dout;
   bit               m_ov;
   bit               m_un;
   int               m_wr_total;
   int               m_rd_total;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_step(input bit w, input bit r, input logic [WIDTH-1:0] din, input bit rs);
      bit was_full, was_empty, wacc, racc;
      if (rs) begin
         q.delete();
         m_dout = '0;
         m_ov = 0;
         m_un = 0;
         m_wr_total = 0;
         m_rd_total = 0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         wacc = w && (!was_full || r);
         racc = r && !was_empty;
         m_ov = w && !wacc;
         m_un = r && !racc;
         if (racc) begin
            m_dout = q.pop_front();
            m_rd_total++;
         end
         if (wacc) begin
            q.push_back(din);
            m_wr_total++;
         end
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(n >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
      chk("d_out", 32'(d_out), 32'(m_dout));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
      chk("wr_ptr", 32'(dut.wr_ptr), 32'(m_wr_total % DEPTH));
      chk("rd_ptr", 32'(dut.rd_ptr), 32'(m_rd_total % DEPTH));
   endtask

   // Drive one cycle of inputs at the falling edge, clock it, check at next falling edge.
   task automatic cycle(input bit w, input bit r, input logic [WIDTH-1:0] din, input bit rs);
      wr   = w;
      rd   = r;
      d_in = din;
      rst  = rs;
      model_step(w, r, din, rs);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_all();
   endtask

   initial begin
      int wr_pct;
      wr = 0; rd = 0; d_in = '0; rst = 0;

      // reset then idle
      cycle(0, 0, 8'h00, 1);
      chk("reset_dout", 32'(d_out), 32'h0);
      chk("reset_empty", 32'(empty), 32'h1);
      cycle(0, 0, 8'h00, 0);

      // fill with 17 writes, last one overflows
      for (int i = 0; i < 17; i++) begin
         cycle(1, 0, 8'(i), 0);
      end
      chk("fill_overflow", 32'(overflow), 32'h1);
      chk("fill_count", 32'(count), 32'd16);
      cycle(0, 0, 8'h00, 0);
      chk("overflow_one_cycle", 32'(overflow), 32'h0);

      // full FIFO simultaneous read/write
      cycle(1, 1, 8'h55, 0);
      chk("full_rw_dout", 32'(d_out), 32'h0);
      chk("full_rw_full", 32'(full), 32'h1);

      // drain 16 then one extra read
      for (int i = 0; i < 16; i++) begin
         cycle(0, 1, 8'h00, 0);
      end
      chk("drain_last", 32'(d_out), 32'h55);
      cycle(0, 1, 8'h00, 0);
      chk("drain_underflow", 32'(underflow), 32'h1);
      chk("drain_hold", 32'(d_out), 32'h55);

      // empty FIFO simultaneous read/write
      cycle(1, 1, 8'h77, 0);
      chk("empty_rw_underflow", 32'(underflow), 32'h1);
      chk("empty_rw_count", 32'(count), 32'd1);
      cycle(0, 1, 8'h00, 0);
      chk("empty_rw_read", 32'(d_out), 32'h77);

      // wrap-around: 10 in, 10 out, then 12 write/read pairs
      for (int i = 0; i < 10; i++) cycle(1, 0, 8'(8'h10 + i), 0);
      for (int i = 0; i < 10; i++) cycle(0, 1, 8'h00, 0);
      for (int i = 0; i < 12; i++) begin
         cycle(1, 0, 8'(8'hA0 + i), 0);
         cycle(0, 1, 8'h00, 0);
         chk("wrap_data", 32'(d_out), 32'(8'hA0 + i));
      end

      // reset mid-operation
      for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h60 + i), 0);
      cycle(0, 1, 8'h00, 1);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_dout", 32'(d_out), 32'h0);
      cycle(1, 0, 8'h3C, 0);
      cycle(0, 1, 8'h00, 0);
      chk("midrst_read", 32'(d_out), 32'h3C);

      // randomized traffic with varying write bias to reach both extremes
      wr_pct = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) begin
            case ($urandom_range(2, 0))
               0:       wr_pct = 20;
               1:       wr_pct = 50;
               default: wr_pct = 85;
            endcase
         end
         cycle(($urandom_range(99, 0) < wr_pct),
               ($urandom_range(99, 0) < (100 - wr_pct)),
               8'($urandom),
               ($urandom_range(399, 0) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
